// File: rtl/usb2_endp_router_if.sv
// Packet-layer / endpoint-buffer bundle for usb2_endp_router.
// master: packet layer + buffers side; slave: the router.
interface usb2_endp_router_if #(
  parameter int NUM_EP = 4
);
  logic [3:0]          sel_endp;
  logic                sel_dir;
  logic                sel_setup;
  logic                sel_valid;
  logic                txn_done;
  logic                txn_abort;
  logic                halt_set;
  logic                halt_clr;
  logic [3:0]          halt_ep;
  logic                cfg_reset;
  logic                sel_ok;
  logic                sel_stall;
  logic [1:0]          endp_mode;
  logic [1:0]          data_toggle;
  logic                buf_in_wren;
  logic [NUM_EP-1:0]   ep_buf_in_wren;
  logic [NUM_EP-1:0]   ep_buf_in_ready;
  logic                buf_in_ready;
  logic [8*NUM_EP-1:0] ep_buf_out_q;
  logic [7:0]          buf_out_q;
  logic [NUM_EP-1:0]   ep_buf_out_hasdata;
  logic                buf_out_hasdata;

  modport master (
    output sel_endp, sel_dir, sel_setup, sel_valid,
    output txn_done, txn_abort,
    output halt_set, halt_clr, halt_ep, cfg_reset,
    output buf_in_wren, ep_buf_in_ready,
    output ep_buf_out_q, ep_buf_out_hasdata,
    input  sel_ok, sel_stall, endp_mode, data_toggle,
    input  ep_buf_in_wren, buf_in_ready,
    input  buf_out_q, buf_out_hasdata
  );

  modport slave (
    input  sel_endp, sel_dir, sel_setup, sel_valid,
    input  txn_done, txn_abort,
    input  halt_set, halt_clr, halt_ep, cfg_reset,
    input  buf_in_wren, ep_buf_in_ready,
    input  ep_buf_out_q, ep_buf_out_hasdata,
    output sel_ok, sel_stall, endp_mode, data_toggle,
    output ep_buf_in_wren, buf_in_ready,
    output buf_out_q, buf_out_hasdata
  );
endinterface

// File: rtl/usb2_endp_router.sv
// USB 2.0 endpoint router: latches token selection, tracks toggle/halt per EP.
// Ports: phy_clk, reset (sync, high), bus (usb2_endp_router_if.slave).
module usb2_endp_router #(
  parameter int          NUM_EP   = 4,
  parameter logic [31:0] EP_MODES = 32'h0000_00A8,
  parameter logic [15:0] EP_DIR   = 16'h0002
) (
  input logic               phy_clk,
  input logic               reset,
  usb2_endp_router_if.slave bus
);
  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t            state;
  logic [3:0]        lsel;
  logic              ldir;
  logic [NUM_EP-1:0] tog;
  logic [NUM_EP-1:0] halt;

  // Zero-extended views so a nonexistent lsel reads 0 safely.
  logic [15:0] tog16;
  logic [15:0] halt16;
  assign tog16  = 16'(tog);
  assign halt16 = 16'(halt);

  logic       active;
  logic       exists;
  logic       dir_match;
  logic       sel_ok;
  logic       sel_stall;
  logic [1:0] lmode;
  logic       setup_hit;
  logic       flip;

  assign active    = (state == ST_ACTIVE);
  assign exists    = ({1'b0, lsel} < 5'(NUM_EP));
  assign dir_match = (lsel == 4'd0) || (EP_DIR[lsel] == ldir);
  assign sel_ok    = active & exists & dir_match & ~halt16[lsel];
  assign sel_stall = active & exists & dir_match & halt16[lsel];

  // Field 0 of EP_MODES is ignored: ep0 is always control.
  assign lmode = (exists && lsel != 4'd0)
               ? EP_MODES[{lsel, 1'b0} +: 2] : 2'd0;

  assign setup_hit = bus.sel_valid & bus.sel_setup
                   & (bus.sel_endp == 4'd0);
  // Isochronous endpoints never leave DATA0.
  assign flip = bus.txn_done & sel_ok & (lmode != 2'd1);

  always_ff @(posedge phy_clk) begin
    if (reset || bus.cfg_reset) begin
      state <= ST_IDLE;
      lsel  <= 4'd0;
      ldir  <= 1'b0;
      tog   <= '0;
      halt  <= '0;
    end else begin
      if (bus.sel_valid) begin
        state <= ST_ACTIVE;
        lsel  <= bus.sel_endp;
        ldir  <= bus.sel_dir;
      end else if (active && (bus.txn_done || bus.txn_abort)) begin
        state <= ST_IDLE;
      end
      for (int i = 0; i < NUM_EP; i++) begin
        if (bus.halt_clr && bus.halt_ep == 4'(i)) begin
          tog[i]  <= 1'b0;
          halt[i] <= 1'b0;
        end else if (i == 0 && setup_hit) begin
          tog[i]  <= 1'b0;
          halt[i] <= 1'b0;
        end else begin
          if (flip && lsel == 4'(i))
            tog[i] <= ~tog[i];
          if (bus.halt_set && bus.halt_ep == 4'(i))
            halt[i] <= 1'b1;
        end
      end
    end
  end

  logic [7:0]        mux_q;
  logic              mux_hasdata;
  logic              mux_ready;
  logic [NUM_EP-1:0] mux_wren;

  always_comb begin
    mux_q       = 8'd0;
    mux_hasdata = 1'b0;
    mux_ready   = 1'b0;
    mux_wren    = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_ok && lsel == 4'(i)) begin
        mux_q       = bus.ep_buf_out_q[8*i +: 8];
        mux_hasdata = bus.ep_buf_out_hasdata[i];
        mux_ready   = bus.ep_buf_in_ready[i];
        if (i == 0 || !EP_DIR[i])
          mux_wren[i] = bus.buf_in_wren;
      end
    end
  end

  assign bus.sel_ok          = sel_ok;
  assign bus.sel_stall       = sel_stall;
  assign bus.endp_mode       = lmode;
  assign bus.data_toggle     = {1'b0, tog16[lsel]};
  assign bus.buf_out_q       = mux_q;
  assign bus.buf_out_hasdata = mux_hasdata;
  assign bus.buf_in_ready    = mux_ready;
  assign bus.ep_buf_in_wren  = mux_wren;
endmodule

// File: tb/tb_usb2_endp_router.sv
// Self-checking bench for usb2_endp_router: directed scenarios + random model.
// Drives bus via usb2_endp_router_if; 4 endpoints, ep3 isochronous.
module tb_usb2_endp_router;
  localparam int          N     = 4;
  localparam logic [31:0] MODES = 32'h0000_0068;
  localparam logic [15:0] DIRS  = 16'h0002;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb2_endp_router_if #(.NUM_EP(N)) bus ();

  usb2_endp_router #(
    .NUM_EP  (N),
    .EP_MODES(MODES),
    .EP_DIR  (DIRS)
  ) dut (
    .phy_clk(clk),
    .reset  (rst),
    .bus    (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  bit m_active;
  int m_lsel;
  bit m_ldir;
  bit m_tog[16];
  bit m_halt[16];

  function automatic int mode_of(int e);
    if (e == 0 || e >= N) return 0;
    return int'(MODES[2*e +: 2]);
  endfunction

  function automatic bit m_valid();
    return m_active && m_lsel < N
        && (m_lsel == 0 || DIRS[m_lsel] == m_ldir);
  endfunction

  function automatic bit m_ok();
    return m_valid() && !m_halt[m_lsel];
  endfunction

  function automatic bit m_stall();
    return m_valid() && m_halt[m_lsel];
  endfunction

  // Apply lowest-priority effects first, higher ones overwrite.
  function automatic void model_step();
    int old;
    bit ok;
    if (rst || bus.cfg_reset) begin
      m_active = 0;
      m_lsel   = 0;
      m_ldir   = 0;
      for (int i = 0; i < 16; i++) begin
        m_tog[i]  = 0;
        m_halt[i] = 0;
      end
      return;
    end
    ok  = m_ok();
    old = m_lsel;
    if (bus.txn_done && ok && mode_of(old) != 1)
      m_tog[old] = !m_tog[old];
    if (bus.halt_set && bus.halt_ep < N)
      m_halt[bus.halt_ep] = 1;
    if (bus.sel_valid && bus.sel_setup && bus.sel_endp == 0) begin
      m_tog[0]  = 0;
      m_halt[0] = 0;
    end
    if (bus.halt_clr && bus.halt_ep < N) begin
      m_tog[bus.halt_ep]  = 0;
      m_halt[bus.halt_ep] = 0;
    end
    if (bus.sel_valid) begin
      m_active = 1;
      m_lsel   = int'(bus.sel_endp);
      m_ldir   = bus.sel_dir;
    end else if (bus.txn_done || bus.txn_abort) begin
      m_active = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    bus.sel_valid = 0;
    bus.sel_setup = 0;
    bus.txn_done  = 0;
    bus.txn_abort = 0;
    bus.halt_set  = 0;
    bus.halt_clr  = 0;
    bus.cfg_reset = 0;
  endtask

  task automatic token(input int ep, input bit dir, input bit setup);
    bus.sel_valid = 1;
    bus.sel_endp  = 4'(ep);
    bus.sel_dir   = dir;
    bus.sel_setup = setup;
    tick();
    clear_in();
  endtask

  task automatic pulse_done();
    bus.txn_done = 1;
    tick();
    clear_in();
  endtask

  task automatic pulse_abort();
    bus.txn_abort = 1;
    tick();
    clear_in();
  endtask

  task automatic test_reset();
    clear_in();
    bus.sel_endp           = 0;
    bus.sel_dir            = 0;
    bus.halt_ep            = 0;
    bus.buf_in_wren        = 1;
    bus.ep_buf_in_ready    = 4'b1111;
    bus.ep_buf_out_q       = 32'h44_33_22_11;
    bus.ep_buf_out_hasdata = 4'b1111;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    n_total++;
    if (bus.sel_ok !== 1'b0 || bus.sel_stall !== 1'b0)
      $display("FAIL reset_sel: ok=%b stall=%b want 0 0",
               bus.sel_ok, bus.sel_stall);
    else n_pass++;
    n_total++;
    if (bus.endp_mode !== 2'd0 || bus.data_toggle !== 2'd0)
      $display("FAIL reset_mode_tog: mode=%0d tog=%0d want 0 0",
               bus.endp_mode, bus.data_toggle);
    else n_pass++;
    n_total++;
    if (bus.buf_out_q !== 8'd0 || bus.ep_buf_in_wren !== 4'd0
        || bus.buf_in_ready !== 1'b0 || bus.buf_out_hasdata !== 1'b0)
      $display("FAIL reset_mux: q=%h wren=%b rdy=%b hd=%b want 0",
               bus.buf_out_q, bus.ep_buf_in_wren,
               bus.buf_in_ready, bus.buf_out_hasdata);
    else n_pass++;
    bus.buf_in_wren = 0;
  endtask

  task automatic test_bulk_toggle();
    logic [1:0] want;
    for (int k = 0; k < 3; k++) begin
      token(1, 1, 0);
      want = (k % 2 == 1) ? 2'd1 : 2'd0;
      n_total++;
      if (bus.data_toggle !== want || bus.sel_ok !== 1'b1)
        $display("FAIL bulk_tog%0d: tog=%0d ok=%b want %0d 1",
                 k, bus.data_toggle, bus.sel_ok, want);
      else n_pass++;
      pulse_done();
    end
    token(1, 1, 0);
    bus.buf_in_wren = 1;
    #1;
    n_total++;
    if (bus.data_toggle !== 2'd1 || bus.endp_mode !== 2'd2)
      $display("FAIL bulk_final: tog=%0d mode=%0d want 1 2",
               bus.data_toggle, bus.endp_mode);
    else n_pass++;
    n_total++;
    if (bus.buf_out_q !== 8'h22 || bus.ep_buf_in_wren !== 4'd0)
      $display("FAIL bulk_mux: q=%h wren=%b want 22 0000",
               bus.buf_out_q, bus.ep_buf_in_wren);
    else n_pass++;
    bus.buf_in_wren = 0;
    pulse_abort();
  endtask

  task automatic test_setup();
    bus.halt_set = 1;
    bus.halt_ep  = 0;
    tick();
    clear_in();
    token(0, 0, 1);
    n_total++;
    if (bus.data_toggle !== 2'd0 || bus.sel_ok !== 1'b1
        || bus.sel_stall !== 1'b0)
      $display("FAIL setup_tok: tog=%0d ok=%b stall=%b want 0 1 0",
               bus.data_toggle, bus.sel_ok, bus.sel_stall);
    else n_pass++;
    pulse_done();
    token(0, 1, 0);
    n_total++;
    if (bus.data_toggle !== 2'd1 || bus.sel_ok !== 1'b1)
      $display("FAIL setup_data: tog=%0d ok=%b want 1 1",
               bus.data_toggle, bus.sel_ok);
    else n_pass++;
    pulse_abort();
    n_total++;
    if (bus.data_toggle !== 2'd1 || bus.sel_ok !== 1'b0)
      $display("FAIL setup_abort: tog=%0d ok=%b want 1 0",
               bus.data_toggle, bus.sel_ok);
    else n_pass++;
  endtask

  task automatic test_halt();
    token(2, 0, 0);
    pulse_done();
    token(2, 0, 0);
    n_total++;
    if (bus.sel_ok !== 1'b1 || bus.data_toggle !== 2'd1)
      $display("FAIL halt_pre: ok=%b tog=%0d want 1 1",
               bus.sel_ok, bus.data_toggle);
    else n_pass++;
    bus.halt_set = 1;
    bus.halt_ep  = 2;
    tick();
    clear_in();
    bus.buf_in_wren = 1;
    #1;
    n_total++;
    if (bus.sel_stall !== 1'b1 || bus.sel_ok !== 1'b0
        || bus.ep_buf_in_wren !== 4'd0)
      $display("FAIL halt_stall: stall=%b ok=%b wren=%b want 1 0 0000",
               bus.sel_stall, bus.sel_ok, bus.ep_buf_in_wren);
    else n_pass++;
    bus.halt_clr = 1;
    bus.halt_ep  = 2;
    tick();
    clear_in();
    n_total++;
    if (bus.sel_ok !== 1'b1 || bus.data_toggle !== 2'd0
        || bus.ep_buf_in_wren !== 4'b0100)
      $display("FAIL halt_clr: ok=%b tog=%0d wren=%b want 1 0 0100",
               bus.sel_ok, bus.data_toggle, bus.ep_buf_in_wren);
    else n_pass++;
    bus.buf_in_wren = 0;
    pulse_abort();
  endtask

  task automatic test_invalid();
    token(7, 1, 0);
    n_total++;
    if (bus.sel_ok !== 1'b0 || bus.sel_stall !== 1'b0
        || bus.buf_out_q !== 8'd0)
      $display("FAIL inv_noep: ok=%b stall=%b q=%h want 0 0 00",
               bus.sel_ok, bus.sel_stall, bus.buf_out_q);
    else n_pass++;
    token(2, 1, 0);
    n_total++;
    if (bus.sel_ok !== 1'b0 || bus.sel_stall !== 1'b0
        || bus.buf_out_q !== 8'd0)
      $display("FAIL inv_dir: ok=%b stall=%b q=%h want 0 0 00",
               bus.sel_ok, bus.sel_stall, bus.buf_out_q);
    else n_pass++;
    pulse_abort();
  endtask

  task automatic test_isoch();
    for (int k = 0; k < 3; k++) begin
      token(3, 0, 0);
      n_total++;
      if (bus.data_toggle !== 2'd0 || bus.endp_mode !== 2'd1
          || bus.sel_ok !== 1'b1)
        $display("FAIL isoch%0d: tog=%0d mode=%0d ok=%b want 0 1 1",
                 k, bus.data_toggle, bus.endp_mode, bus.sel_ok);
      else n_pass++;
      pulse_done();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    token(1, 1, 0);
    want = {1'b0, !m_tog[1]};
    bus.txn_done  = 1;
    bus.sel_valid = 1;
    bus.sel_endp  = 2;
    bus.sel_dir   = 0;
    tick();
    clear_in();
    n_total++;
    if (bus.sel_ok !== 1'b1 || bus.endp_mode !== 2'd2
        || bus.buf_out_q !== 8'h33)
      $display("FAIL b2b_sel: ok=%b mode=%0d q=%h want 1 2 33",
               bus.sel_ok, bus.endp_mode, bus.buf_out_q);
    else n_pass++;
    pulse_abort();
    token(1, 1, 0);
    n_total++;
    if (bus.data_toggle !== want)
      $display("FAIL b2b_flip: tog=%0d want %0d",
               bus.data_toggle, want);
    else n_pass++;
    bus.cfg_reset = 1;
    tick();
    clear_in();
    n_total++;
    if (bus.sel_ok !== 1'b0 || bus.data_toggle !== 2'd0)
      $display("FAIL cfg_reset: ok=%b tog=%0d want 0 0",
               bus.sel_ok, bus.data_toggle);
    else n_pass++;
    token(1, 1, 0);
    n_total++;
    if (bus.data_toggle !== 2'd0 || bus.sel_ok !== 1'b1)
      $display("FAIL cfg_tog: tog=%0d ok=%b want 0 1",
               bus.data_toggle, bus.sel_ok);
    else n_pass++;
    pulse_abort();
  endtask

  task automatic test_precedence();
    bus.halt_set = 1;
    bus.halt_clr = 1;
    bus.halt_ep  = 1;
    tick();
    clear_in();
    token(1, 1, 0);
    n_total++;
    if (bus.sel_ok !== 1'b1 || bus.sel_stall !== 1'b0)
      $display("FAIL prec_halt: ok=%b stall=%b want 1 0",
               bus.sel_ok, bus.sel_stall);
    else n_pass++;
    bus.txn_done = 1;
    bus.halt_clr = 1;
    bus.halt_ep  = 1;
    tick();
    clear_in();
    token(1, 1, 0);
    n_total++;
    if (bus.data_toggle !== 2'd0)
      $display("FAIL prec_tog: tog=%0d want 0", bus.data_toggle);
    else n_pass++;
    pulse_abort();
  endtask

  task automatic test_random();
    logic [31:0] rq;
    logic [3:0]  rr;
    logic [3:0]  rh;
    logic [7:0]  e_q;
    logic [3:0]  e_wren;
    logic [1:0]  e_mode;
    logic [1:0]  e_tog;
    bit          e_ok;
    bit          e_stall;
    bit          e_rdy;
    bit          e_hd;
    for (int c = 0; c < 800; c++) begin
      rq = $urandom;
      rr = 4'($urandom);
      rh = 4'($urandom);
      rst                    = ($urandom_range(0, 99) == 0);
      bus.sel_valid          = ($urandom_range(0, 99) < 30);
      bus.sel_endp           = 4'($urandom_range(0, 5));
      bus.sel_dir            = 1'($urandom_range(0, 1));
      bus.sel_setup          = ($urandom_range(0, 99) < 25);
      bus.txn_done           = ($urandom_range(0, 99) < 30);
      bus.txn_abort          = ($urandom_range(0, 99) < 10);
      bus.halt_set           = ($urandom_range(0, 99) < 6);
      bus.halt_clr           = ($urandom_range(0, 99) < 6);
      bus.halt_ep            = 4'($urandom_range(0, 5));
      bus.cfg_reset          = ($urandom_range(0, 99) < 2);
      bus.buf_in_wren        = 1'($urandom_range(0, 1));
      bus.ep_buf_out_q       = rq;
      bus.ep_buf_in_ready    = rr;
      bus.ep_buf_out_hasdata = rh;
      tick();
      e_ok    = m_ok();
      e_stall = m_stall();
      e_mode  = 2'(mode_of(m_lsel));
      e_tog   = (m_lsel < N) ? {1'b0, m_tog[m_lsel]} : 2'd0;
      e_q     = e_ok ? 8'(rq >> (8 * m_lsel)) : 8'd0;
      e_rdy   = e_ok ? 1'(rr >> m_lsel) : 1'b0;
      e_hd    = e_ok ? 1'(rh >> m_lsel) : 1'b0;
      e_wren  = (bus.buf_in_wren && e_ok
                 && (m_lsel == 0 || !DIRS[m_lsel]))
              ? 4'(1 << m_lsel) : 4'd0;
      n_total++;
      if (bus.sel_ok !== e_ok)
        $display("FAIL rnd_ok c%0d: got %b want %b", c, bus.sel_ok, e_ok);
      else n_pass++;
      n_total++;
      if (bus.sel_stall !== e_stall)
        $display("FAIL rnd_stall c%0d: got %b want %b",
                 c, bus.sel_stall, e_stall);
      else n_pass++;
      n_total++;
      if (bus.endp_mode !== e_mode)
        $display("FAIL rnd_mode c%0d: got %0d want %0d",
                 c, bus.endp_mode, e_mode);
      else n_pass++;
      n_total++;
      if (bus.data_toggle !== e_tog)
        $display("FAIL rnd_tog c%0d: got %0d want %0d",
                 c, bus.data_toggle, e_tog);
      else n_pass++;
      n_total++;
      if (bus.buf_out_q !== e_q)
        $display("FAIL rnd_q c%0d: got %h want %h", c, bus.buf_out_q, e_q);
      else n_pass++;
      n_total++;
      if (bus.buf_in_ready !== e_rdy || bus.buf_out_hasdata !== e_hd)
        $display("FAIL rnd_rdy_hd c%0d: got %b%b want %b%b", c,
                 bus.buf_in_ready, bus.buf_out_hasdata, e_rdy, e_hd);
      else n_pass++;
      n_total++;
      if (bus.ep_buf_in_wren !== e_wren)
        $display("FAIL rnd_wren c%0d: got %b want %b",
                 c, bus.ep_buf_in_wren, e_wren);
      else n_pass++;
    end
    rst = 0;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_bulk_toggle();
    test_setup();
    test_halt();
    test_invalid();
    test_isoch();
    test_back_to_back();
    test_precedence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
